ctrl_ramdrv_ringbuf_wr: RTL and testbench

Ring-buffer write-side controller for the sample segment of the controller RAM driver. Accepts incoming input samples over a valid/ready handshake and writes each one to the RAM at the next head position, wrapping within the segment. Publishes the current head pointer and fill level to the read-side address counter. Defers each write while a read pass is running, so the oldest sample is never overwritten mid-pass.

---
 rtl/ctrl_ramdrv_ringbuf_wr_pkg.sv | 15 +
 rtl/ctrl_ramdrv_ringbuf_wr_if.sv | 29 ++
 rtl/ctrl_ramdrv_ptr_wrap.sv | 24 ++
 rtl/ctrl_ramdrv_ringbuf_wr.sv | 145 ++++++++++++++
 tb/tb_ctrl_ramdrv_ringbuf_wr.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_ramdrv_ringbuf_wr_pkg.sv
// rtl/ctrl_ramdrv_ringbuf_wr_pkg.sv - shared types and defaults for the ring-buffer write side
package ctrl_ramdrv_ringbuf_wr_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 16;

  // Encoding is shared with the read-side address counter, keep values stable.
  typedef enum logic [1:0] {
    ST_UNINIT = 2'd0,
    ST_IDLE   = 2'd1,
    ST_PEND   = 2'd2,
    ST_WR     = 2'd3
  } wr_state_e;

endpackage

// File: rtl/ctrl_ramdrv_ringbuf_wr_if.sv
// rtl/ctrl_ramdrv_ringbuf_wr_if.sv - sample handshake and RAM write port bundle
interface ctrl_ramdrv_ringbuf_wr_if
  import ctrl_ramdrv_ringbuf_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  smpl_valid;
  logic [DATA_WIDTH-1:0] smpl_data;
  logic                  smpl_ready;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  // Environment side: sample producer and RAM.
  modport master (
    output smpl_valid, smpl_data,
    input  smpl_ready, ram_we, ram_waddr, ram_wdata
  );

  // Controller side.
  modport slave (
    input  smpl_valid, smpl_data,
    output smpl_ready, ram_we, ram_waddr, ram_wdata
  );

endinterface

// File: rtl/ctrl_ramdrv_ptr_wrap.sv
// rtl/ctrl_ramdrv_ptr_wrap.sv - combinational pointer step with wrap inside [bptr, lptr]
module ctrl_ramdrv_ptr_wrap #(
  parameter int W         = 12,
  parameter bit DECREMENT = 1'b0
) (
  input  logic [W-1:0] ptr_i,
  input  logic [W-1:0] bptr_i,
  input  logic [W-1:0] lptr_i,
  output logic [W-1:0] next_o
);

  localparam logic [W-1:0] ONE = W'(1);

  // Increment wraps last->base; the decrement variant (read side) wraps base->last.
  always_comb begin
    next_o = ptr_i;
    if (DECREMENT) begin
      next_o = (ptr_i == bptr_i) ? lptr_i : ptr_i - ONE;
    end else begin
      next_o = (ptr_i == lptr_i) ? bptr_i : ptr_i + ONE;
    end
  end

endmodule

// File: rtl/ctrl_ramdrv_ringbuf_wr.sv
// rtl/ctrl_ramdrv_ringbuf_wr.sv - ring-buffer write-side controller for the RAM sample segment
module ctrl_ramdrv_ringbuf_wr
  import ctrl_ramdrv_ringbuf_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] data_bptr,
  input  logic [ADDR_WIDTH-1:0] data_lptr,
  input  logic                  rd_busy,
  ctrl_ramdrv_ringbuf_wr_if.slave bus,
  output logic [ADDR_WIDTH-1:0] data_hptr,
  output logic [ADDR_WIDTH:0]   fill,
  output logic                  full,
  output logic                  smpl_new
);

  localparam logic [ADDR_WIDTH:0] FILL_ONE = (ADDR_WIDTH+1)'(1);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] bptr_q, lptr_q, hptr_q;
  logic [ADDR_WIDTH:0]   fill_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  smpl_new_q;

  logic                  ready_c;
  logic                  wr_fire;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] next_ptr;
  logic [ADDR_WIDTH:0]   seg_size;
  logic [ADDR_WIDTH:0]   fill_next;

  ctrl_ramdrv_ptr_wrap #(
    .W         (ADDR_WIDTH),
    .DECREMENT (1'b0)
  ) u_wrap (
    .ptr_i  (hptr_q),
    .bptr_i (bptr_q),
    .lptr_i (lptr_q),
    .next_o (next_ptr)
  );

  // Segment size is one wider than the address so a full-range segment still fits.
  // lptr < bptr is not a legal configuration; the result is then meaningless.
  assign seg_size  = {1'b0, lptr_q} - {1'b0, bptr_q} + FILL_ONE;
  assign fill_next = (fill_q >= seg_size) ? seg_size : fill_q + FILL_ONE;
  assign accept    = ready_c & bus.smpl_valid;

  // Next-state and handshake/write strobes; init overrides everything but reset.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    wr_fire = 1'b0;
    if (init) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_UNINIT: state_d = ST_UNINIT;
        ST_IDLE: begin
          ready_c = 1'b1;
          if (bus.smpl_valid) begin
            state_d = rd_busy ? ST_PEND : ST_WR;
          end
        end
        ST_PEND: begin
          if (!rd_busy) begin
            state_d = ST_WR;
          end
        end
        ST_WR: begin
          wr_fire = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_UNINIT;
      endcase
    end
  end

  // State register, falling-edge clocked like the rest of the RAM driver.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= ST_UNINIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold register captures the sample at handshake so it survives a PEND wait.
  always_ff @(negedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= bus.smpl_data;
    end
  end

  // Segment bounds, head pointer and fill level.
  always_ff @(negedge clk) begin
    if (rst) begin
      bptr_q <= '0;
      lptr_q <= '0;
      hptr_q <= '0;
      fill_q <= '0;
    end else if (init) begin
      bptr_q <= data_bptr;
      lptr_q <= data_lptr;
      hptr_q <= data_lptr;
      fill_q <= '0;
    end else if (wr_fire) begin
      hptr_q <= next_ptr;
      fill_q <= fill_next;
    end
  end

  // Last written address/data are kept so the RAM port is stable between writes.
  always_ff @(negedge clk) begin
    if (rst) begin
      waddr_q    <= '0;
      wdata_q    <= '0;
      smpl_new_q <= 1'b0;
    end else begin
      smpl_new_q <= wr_fire;
      if (wr_fire) begin
        waddr_q <= next_ptr;
        wdata_q <= hold_q;
      end
    end
  end

  assign bus.smpl_ready = ready_c;
  assign bus.ram_we     = wr_fire;
  assign bus.ram_waddr  = wr_fire ? next_ptr : waddr_q;
  assign bus.ram_wdata  = wr_fire ? hold_q : wdata_q;

  assign data_hptr = hptr_q;
  assign fill      = fill_q;
  assign full      = (fill_q == seg_size);
  assign smpl_new  = smpl_new_q;

endmodule

// File: tb/tb_ctrl_ramdrv_ringbuf_wr.sv
// tb/tb_ctrl_ramdrv_ringbuf_wr.sv - directed scoreboard bench for the ring-buffer write side
module tb_ctrl_ramdrv_ringbuf_wr;

  logic        clk;
  logic        rst;
  logic        init;
  logic [11:0] bptr;
  logic [11:0] lptr;
  logic        rd_busy;
  logic [11:0] data_hptr;
  logic [12:0] fill;
  logic        full;
  logic        smpl_new;

  int n_vec = 0;
  int n_err = 0;
  int new_cnt = 0;
  int wr_cnt = 0;
  int n0;
  int w0;

  logic [27:0] sbq[$];
  logic [27:0] sb_e;
  logic [11:0] exp_a [5];

  ctrl_ramdrv_ringbuf_wr_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

  ctrl_ramdrv_ringbuf_wr #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .data_bptr (bptr),
    .data_lptr (lptr),
    .rd_busy   (rd_busy),
    .bus       (bus),
    .data_hptr (data_hptr),
    .fill      (fill),
    .full      (full),
    .smpl_new  (smpl_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called just after a rising edge; returns at the rising edge after the accept cycle.
  task automatic send(input logic [15:0] d, input logic [11:0] a, input bit expect_wr);
    int n = 0;
    bus.smpl_valid = 1'b1;
    bus.smpl_data  = d;
    #1;
    while (bus.smpl_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_timeout", {31'd0, (n < 20)}, 32'd1);
    if (expect_wr) sbq.push_back({a, d});
    @(posedge clk);
    bus.smpl_valid = 1'b0;
  endtask

  // Write monitor: every RAM write pops the scoreboard.
  always @(posedge clk) begin
    #3;
    if (smpl_new === 1'b1) new_cnt++;
    if (bus.ram_we === 1'b1) begin
      wr_cnt++;
      if (sbq.size() == 0) begin
        check("unexpected_write", {20'd0, bus.ram_waddr}, 32'hFFFF_FFFF);
      end else begin
        sb_e = sbq.pop_front();
        check("wr_addr", {20'd0, bus.ram_waddr}, {20'd0, sb_e[27:16]});
        check("wr_data", {16'd0, bus.ram_wdata}, {16'd0, sb_e[15:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_a = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h010};
    rst = 1'b1; init = 1'b0; bptr = '0; lptr = '0; rd_busy = 1'b0;
    bus.smpl_valid = 1'b1; bus.smpl_data = 16'hDEAD;

    // 1: reset, then samples ignored before init
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.smpl_ready}, 0);
    check("rst_we", {31'd0, bus.ram_we}, 0);
    check("rst_waddr", {20'd0, bus.ram_waddr}, 0);
    check("rst_wdata", {16'd0, bus.ram_wdata}, 0);
    check("rst_hptr", {20'd0, data_hptr}, 0);
    check("rst_fill", {19'd0, fill}, 0);
    check("rst_full", {31'd0, full}, 0);
    check("rst_new", {31'd0, smpl_new}, 0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("uninit_ready", {31'd0, bus.smpl_ready}, 0);
      check("uninit_we", {31'd0, bus.ram_we}, 0);
    end
    check("uninit_hptr", {20'd0, data_hptr}, 0);
    check("uninit_fill", {19'd0, fill}, 0);
    bus.smpl_valid = 1'b0;

    // 2: init, single write
    @(posedge clk);
    init = 1'b1; bptr = 12'h010; lptr = 12'h013;
    #1;
    check("init_ready", {31'd0, bus.smpl_ready}, 0);
    check("init_we", {31'd0, bus.ram_we}, 0);
    @(posedge clk);
    init = 1'b0;
    #1;
    check("init_hptr", {20'd0, data_hptr}, 32'h013);
    check("init_fill", {19'd0, fill}, 0);
    check("idle_ready", {31'd0, bus.smpl_ready}, 1);
    n0 = new_cnt;
    send(16'hA5A5, 12'h010, 1'b1);
    #1;
    check("t2_we", {31'd0, bus.ram_we}, 1);
    check("t2_addr", {20'd0, bus.ram_waddr}, 32'h010);
    check("t2_data", {16'd0, bus.ram_wdata}, 32'hA5A5);
    check("t2_hptr_before", {20'd0, data_hptr}, 32'h013);
    @(posedge clk); #1;
    check("t2_hptr", {20'd0, data_hptr}, 32'h010);
    check("t2_fill", {19'd0, fill}, 1);
    check("t2_new", {31'd0, smpl_new}, 1);
    check("t2_full", {31'd0, full}, 0);
    @(posedge clk); #1;
    check("t2_new_low", {31'd0, smpl_new}, 0);
    check("t2_new_cnt", new_cnt - n0, 1);
    check("t2_hold_addr", {20'd0, bus.ram_waddr}, 32'h010);

    // 3: five back-to-back samples with wrap and overwrite
    @(posedge clk); init = 1'b1;
    @(posedge clk); init = 1'b0;
    n0 = new_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        check("t3_fill", {19'd0, fill}, (i >= 4) ? 4 : i);
        check("t3_full", {31'd0, full}, (i >= 4) ? 1 : 0);
      end
      send(16'h1000 + 16'(i), exp_a[i], 1'b1);
      #1;
      check("t3_we", {31'd0, bus.ram_we}, 1);
      check("t3_ready_wr", {31'd0, bus.smpl_ready}, 0);
    end
    @(posedge clk); #1;
    check("t3_fill_final", {19'd0, fill}, 4);
    check("t3_full_final", {31'd0, full}, 1);
    check("t3_hptr_final", {20'd0, data_hptr}, 32'h010);
    @(posedge clk); #1;
    check("t3_new_cnt", new_cnt - n0, 5);

    // 4: read pass defers the write
    @(posedge clk);
    rd_busy = 1'b1;
    w0 = wr_cnt;
    send(16'hBEEF, 12'h011, 1'b1);
    bus.smpl_data = 16'h0000;
    #1;
    check("t4_ready", {31'd0, bus.smpl_ready}, 0);
    check("t4_we", {31'd0, bus.ram_we}, 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("t4_ready", {31'd0, bus.smpl_ready}, 0);
      check("t4_we", {31'd0, bus.ram_we}, 0);
    end
    @(posedge clk);
    rd_busy = 1'b0;
    #1;
    check("t4_we_fall", {31'd0, bus.ram_we}, 0);
    @(posedge clk); #1;
    check("t4_we_go", {31'd0, bus.ram_we}, 1);
    check("t4_addr", {20'd0, bus.ram_waddr}, 32'h011);
    check("t4_data", {16'd0, bus.ram_wdata}, 32'hBEEF);
    @(posedge clk); #1;
    check("t4_wr_cnt", wr_cnt - w0, 1);
    check("t4_hptr", {20'd0, data_hptr}, 32'h011);
    check("t4_fill", {19'd0, fill}, 4);

    // 5: init while pending drops the sample
    @(posedge clk);
    rd_busy = 1'b1;
    w0 = wr_cnt;
    send(16'h1234, 12'h000, 1'b0);
    #1;
    @(posedge clk);
    init = 1'b1;
    #1;
    check("t5_we_init", {31'd0, bus.ram_we}, 0);
    @(posedge clk);
    init = 1'b0; rd_busy = 1'b0;
    #1;
    check("t5_hptr", {20'd0, data_hptr}, 32'h013);
    check("t5_fill", {19'd0, fill}, 0);
    check("t5_full", {31'd0, full}, 0);
    check("t5_ready", {31'd0, bus.smpl_ready}, 1);
    repeat (2) begin
      @(posedge clk); #1;
      check("t5_no_we", {31'd0, bus.ram_we}, 0);
    end
    check("t5_no_wr", wr_cnt - w0, 0);
    send(16'h5678, 12'h010, 1'b1);
    #1;
    check("t5_addr", {20'd0, bus.ram_waddr}, 32'h010);
    @(posedge clk); #1;
    check("t5_hptr_after", {20'd0, data_hptr}, 32'h010);
    check("t5_fill_after", {19'd0, fill}, 1);

    // 6: single-entry segment
    @(posedge clk);
    init = 1'b1; bptr = 12'h020; lptr = 12'h020;
    @(posedge clk);
    init = 1'b0;
    #1;
    check("t6_hptr_init", {20'd0, data_hptr}, 32'h020);
    check("t6_full_init", {31'd0, full}, 0);
    for (int i = 0; i < 3; i++) begin
      send(16'hC000 + 16'(i), 12'h020, 1'b1);
      #1;
      check("t6_addr", {20'd0, bus.ram_waddr}, 32'h020);
      @(posedge clk); #1;
      check("t6_fill", {19'd0, fill}, 1);
      check("t6_full", {31'd0, full}, 1);
      check("t6_hptr", {20'd0, data_hptr}, 32'h020);
    end

    @(posedge clk); #1;
    check("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
